// File: rtl/yags_update_scheduler_if.sv
// ----------------------------------------------------------------------------
// yags_update_scheduler_if
//
// Bundles the two buses of the YAGS update scheduler:
//   - resolution channel from execute (valid/ready handshake)
//       res_valid, res_ready, res_pc, res_history, res_taken,
//       res_mispredict, res_counter
//   - PHT update port
//       pht_update, pht_miss_predict, pht_address, pht_history,
//       pht_actual_prediction
//
// Modports:
//   slave  : the scheduler (consumes resolutions, drives the PHT port)
//   master : the surrounding pipeline (produces resolutions, observes PHT port)
// ----------------------------------------------------------------------------
interface yags_update_scheduler_if #(
  parameter int GHR_SIZE = 10,
  parameter int PC_SIZE  = 10
);

  // Resolution channel
  logic                res_valid;
  logic                res_ready;
  logic [PC_SIZE-1:0]  res_pc;
  logic [GHR_SIZE-1:0] res_history;
  logic                res_taken;
  logic                res_mispredict;
  logic [1:0]          res_counter;

  // PHT update port
  logic                pht_update;
  logic                pht_miss_predict;
  logic [PC_SIZE-1:0]  pht_address;
  logic [GHR_SIZE-1:0] pht_history;
  logic [1:0]          pht_actual_prediction;

  modport slave (
    input  res_valid, res_pc, res_history, res_taken, res_mispredict, res_counter,
    output res_ready,
    output pht_update, pht_miss_predict, pht_address, pht_history,
           pht_actual_prediction
  );

  modport master (
    output res_valid, res_pc, res_history, res_taken, res_mispredict, res_counter,
    input  res_ready,
    input  pht_update, pht_miss_predict, pht_address, pht_history,
           pht_actual_prediction
  );

endinterface

// File: rtl/yags_update_scheduler.sv
// ----------------------------------------------------------------------------
// yags_update_scheduler
//
// Sequences updates into the YAGS direction PHT and owns the speculative
// global history register used at fetch.
//   - Resolutions from execute are queued in an in-order FIFO and drained into
//     the PHT update port, at most one per cycle.
//   - An update whose PC collides with a same-cycle PHT lookup is deferred, but
//     never for more than MAX_DEFER consecutive cycles.
//   - A mispredict restores the GHR from the resolution's snapshot and marks it
//     invalid for RECOVER_CYCLES cycles.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   pred_valid, pred_taken fetch-time prediction shifting into the GHR
//   rd_valid, rd_address   PHT lookup happening this cycle
//   ghr, ghr_valid         speculative history and its validity
//   bus (slave)            resolution handshake in, PHT update port out
// ----------------------------------------------------------------------------
module yags_update_scheduler #(
  parameter int GHR_SIZE       = 10,
  parameter int PC_SIZE        = 10,
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_DEFER      = 3,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  input  logic                pred_taken,
  input  logic                rd_valid,
  input  logic [PC_SIZE-1:0]  rd_address,
  output logic [GHR_SIZE-1:0] ghr,
  output logic                ghr_valid,
  yags_update_scheduler_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DEF_W = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
  localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic {
    RUN,
    RECOVER
  } state_t;

  typedef struct packed {
    logic [PC_SIZE-1:0]  pc;
    logic [GHR_SIZE-1:0] history;
    logic                mispredict;
    logic [1:0]          counter;
  } entry_t;

  // 2-bit saturating counter update.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) res = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
    else       res = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q,     state_d;
  logic [REC_W-1:0]    rec_cnt_q,   rec_cnt_d;
  logic [GHR_SIZE-1:0] ghr_q,       ghr_d;
  logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]    count_q,     count_d;
  logic [DEF_W-1:0]    defer_cnt_q, defer_cnt_d;

  logic                pht_update_q,       pht_update_d;
  logic                pht_miss_predict_q, pht_miss_predict_d;
  logic [PC_SIZE-1:0]  pht_address_q,      pht_address_d;
  logic [GHR_SIZE-1:0] pht_history_q,      pht_history_d;
  logic [1:0]          pht_actual_q,       pht_actual_d;

  entry_t mem_q [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic   res_ready;
  logic   accept;
  logic   accept_mp;
  logic   not_empty;
  logic   defer;
  logic   issue;
  entry_t head;
  entry_t push_entry;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    res_ready  = (count_q < CNT_W'(FIFO_DEPTH));
    accept     = bus.res_valid && res_ready;
    accept_mp  = accept && bus.res_mispredict;
    not_empty  = (count_q != '0);
    head       = mem_q[rd_ptr_q];

    // A lookup of the same PC this cycle wins the PHT port, until the deferral
    // budget runs out and the head is forced through.
    defer = not_empty && rd_valid && (rd_address == head.pc) &&
            (defer_cnt_q < DEF_W'(MAX_DEFER));
    issue = not_empty && !defer;

    push_entry.pc         = bus.res_pc;
    push_entry.history    = bus.res_history;
    push_entry.mispredict = bus.res_mispredict;
    push_entry.counter    = sat_update(bus.res_counter, bus.res_taken);

    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = issue  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    case ({accept, issue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    defer_cnt_d = defer_cnt_q;
    if (defer)      defer_cnt_d = defer_cnt_q + DEF_W'(1);
    else if (issue) defer_cnt_d = '0;

    // PHT outputs are loaded from the head on issue and otherwise hold.
    pht_update_d       = issue;
    pht_miss_predict_d = pht_miss_predict_q;
    pht_address_d      = pht_address_q;
    pht_history_d      = pht_history_q;
    pht_actual_d       = pht_actual_q;
    if (issue) begin
      pht_miss_predict_d = head.mispredict;
      pht_address_d      = head.pc;
      pht_history_d      = head.history;
      pht_actual_d       = head.counter;
    end
  end

  // --------------------------------------------------------------------------
  // Recovery FSM and GHR
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    ghr_d     = ghr_q;

    case (state_q)
      RUN: begin
        if (accept_mp) begin
          state_d   = RECOVER;
          rec_cnt_d = REC_W'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        // A fresh mispredict restarts the window rather than extending it.
        if (accept_mp) begin
          rec_cnt_d = REC_W'(RECOVER_CYCLES - 1);
        end else if (rec_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          rec_cnt_d = rec_cnt_q - REC_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    // The snapshot already excludes the mispredicted branch, so append its
    // actual outcome; this overrides any same-cycle speculative shift.
    if (accept_mp) begin
      ghr_d = {bus.res_history[GHR_SIZE-2:0], bus.res_taken};
    end else if (state_q == RUN && pred_valid) begin
      ghr_d = {ghr_q[GHR_SIZE-2:0], pred_taken};
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q            <= RUN;
      rec_cnt_q          <= '0;
      ghr_q              <= '0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      count_q            <= '0;
      defer_cnt_q        <= '0;
      pht_update_q       <= 1'b0;
      pht_miss_predict_q <= 1'b0;
      pht_address_q      <= '0;
      pht_history_q      <= '0;
      pht_actual_q       <= '0;
    end else begin
      state_q            <= state_d;
      rec_cnt_q          <= rec_cnt_d;
      ghr_q              <= ghr_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      count_q            <= count_d;
      defer_cnt_q        <= defer_cnt_d;
      pht_update_q       <= pht_update_d;
      pht_miss_predict_q <= pht_miss_predict_d;
      pht_address_q      <= pht_address_d;
      pht_history_q      <= pht_history_d;
      pht_actual_q       <= pht_actual_d;
    end
  end

  // NOTE: FIFO storage is not reset; occupancy is tracked by count_q, so stale
  // slots are never read as valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ghr       = ghr_q;
  assign ghr_valid = (state_q == RUN);

  assign bus.res_ready             = res_ready;
  assign bus.pht_update            = pht_update_q;
  assign bus.pht_miss_predict      = pht_miss_predict_q;
  assign bus.pht_address           = pht_address_q;
  assign bus.pht_history           = pht_history_q;
  assign bus.pht_actual_prediction = pht_actual_q;

endmodule

// File: tb/tb_yags_update_scheduler.sv
// ----------------------------------------------------------------------------
// tb_yags_update_scheduler
//
// Directed bench for yags_update_scheduler. Expected PHT updates are pushed to
// a scoreboard queue when a resolution is accepted and popped when the DUT
// strobes pht_update; GHR, handshake and timing points are checked directly.
// ----------------------------------------------------------------------------
module tb_yags_update_scheduler;

  localparam int GHR_SIZE = 10;
  localparam int PC_SIZE  = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                pred_valid;
  logic                pred_taken;
  logic                rd_valid;
  logic [PC_SIZE-1:0]  rd_address;
  logic [GHR_SIZE-1:0] ghr;
  logic                ghr_valid;

  yags_update_scheduler_if #(.GHR_SIZE(GHR_SIZE), .PC_SIZE(PC_SIZE)) bus ();

  yags_update_scheduler #(
    .GHR_SIZE      (GHR_SIZE),
    .PC_SIZE       (PC_SIZE),
    .FIFO_DEPTH    (4),
    .MAX_DEFER     (3),
    .RECOVER_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .rd_valid  (rd_valid),
    .rd_address(rd_address),
    .ghr       (ghr),
    .ghr_valid (ghr_valid),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {mispredict, pc, history, new counter}
  logic [22:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [9:0] pc, input logic [9:0] hist,
                           input logic taken, input logic mp, input logic [1:0] ctr);
    bus.res_valid      = 1'b1;
    bus.res_pc         = pc;
    bus.res_history    = hist;
    bus.res_taken      = taken;
    bus.res_mispredict = mp;
    bus.res_counter    = ctr;
  endtask

  task automatic expect_update(input logic [9:0] pc, input logic [9:0] hist,
                               input logic taken, input logic mp, input logic [1:0] ctr);
    sb.push_back({mp, pc, hist, next_ctr(ctr, taken)});
  endtask

  // Present a resolution for one edge; queue the expected update if accepted.
  task automatic send(input logic [9:0] pc, input logic [9:0] hist,
                      input logic taken, input logic mp, input logic [1:0] ctr);
    logic rdy;
    drive_res(pc, hist, taken, mp, ctr);
    rdy = bus.res_ready;
    tick();
    if (rdy) expect_update(pc, hist, taken, mp, ctr);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: every PHT strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.pht_update === 1'b1) begin
      check("pht_update_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        check("pht_entry",
              {9'd0, bus.pht_miss_predict, bus.pht_address, bus.pht_history,
               bus.pht_actual_prediction},
              {9'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst                = 1'b1;
    pred_valid         = 1'b0;
    pred_taken         = 1'b0;
    rd_valid           = 1'b0;
    rd_address         = '0;
    bus.res_valid      = 1'b0;
    bus.res_pc         = '0;
    bus.res_history    = '0;
    bus.res_taken      = 1'b0;
    bus.res_mispredict = 1'b0;
    bus.res_counter    = '0;

    // Reset state
    tick();
    tick();
    check("rst_ghr",        32'(ghr), 32'h000);
    check("rst_ghr_valid",  32'(ghr_valid), 32'd1);
    check("rst_res_ready",  32'(bus.res_ready), 32'd1);
    check("rst_pht_update", 32'(bus.pht_update), 32'd0);
    check("rst_pht_addr",   32'(bus.pht_address), 32'd0);
    check("rst_pht_ctr",    32'(bus.pht_actual_prediction), 32'd0);
    rst = 1'b0;

    // Speculative history shifting
    pred_valid = 1'b1;
    pred_taken = 1'b1; tick(); check("ghr_shift1", 32'(ghr), 32'h001);
    pred_taken = 1'b1; tick(); check("ghr_shift2", 32'(ghr), 32'h003);
    pred_taken = 1'b0; tick(); check("ghr_shift3", 32'(ghr), 32'h006);
    pred_valid = 1'b0;
    check("ghr_valid_run", 32'(ghr_valid), 32'd1);

    // Single update, saturation at both ends
    send(10'h011, 10'h001, 1'b1, 1'b0, 2'd2);
    bus.res_valid = 1'b0;
    check("t2_not_yet", 32'(bus.pht_update), 32'd0);
    tick();
    check("t2_update",  32'(bus.pht_update), 32'd1);
    check("t2_addr",    32'(bus.pht_address), 32'h011);
    check("t2_hist",    32'(bus.pht_history), 32'h001);
    check("t2_ctr",     32'(bus.pht_actual_prediction), 32'd3);
    check("t2_mp",      32'(bus.pht_miss_predict), 32'd0);
    tick();
    check("t2_pulse",   32'(bus.pht_update), 32'd0);
    send(10'h011, 10'h001, 1'b1, 1'b0, 2'd3);
    bus.res_valid = 1'b0;
    tick(); tick();
    send(10'h015, 10'h2AA, 1'b0, 1'b0, 2'd0);
    bus.res_valid = 1'b0;
    tick(); tick();
    check("t2_hold_addr", 32'(bus.pht_address), 32'h015);
    check("t2_ghr_kept",  32'(ghr), 32'h006);
    wait_drain("t2_drain");

    // Mispredict recovery overriding a same-cycle prediction
    pred_valid = 1'b1;
    pred_taken = 1'b1;
    send(10'h040, 10'h0FE, 1'b0, 1'b1, 2'd1);
    bus.res_valid = 1'b0;
    check("t3_ghr_restore", 32'(ghr), 32'h1FC);
    check("t3_invalid1",    32'(ghr_valid), 32'd0);
    tick();
    check("t3_ghr_frozen",  32'(ghr), 32'h1FC);
    check("t3_invalid2",    32'(ghr_valid), 32'd0);
    tick();
    check("t3_valid_again", 32'(ghr_valid), 32'd1);
    check("t3_ghr_frozen2", 32'(ghr), 32'h1FC);
    tick();
    check("t3_ghr_shift",   32'(ghr), 32'h3F9);
    pred_valid = 1'b0;
    wait_drain("t3_drain");

    // Collision deferral, full FIFO, forced issue
    rd_valid   = 1'b1;
    rd_address = 10'h020;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      drive_res(10'h020, 10'(10'h100 + iv), iv[0], 1'b0, iv[1:0]);
      check("t4_ready_pre", 32'(bus.res_ready), 32'd1);
      tick();
      expect_update(10'h020, 10'(10'h100 + iv), iv[0], 1'b0, iv[1:0]);
      if (i > 0) check("t4_deferred", 32'(bus.pht_update), 32'd0);
    end
    check("t4_full", 32'(bus.res_ready), 32'd0);
    drive_res(10'h020, 10'h1FF, 1'b1, 1'b0, 2'd1);
    tick();
    check("t4_forced",       32'(bus.pht_update), 32'd1);
    check("t4_ready_after",  32'(bus.res_ready), 32'd1);
    tick();
    expect_update(10'h020, 10'h1FF, 1'b1, 1'b0, 2'd1);
    bus.res_valid = 1'b0;
    rd_valid      = 1'b0;
    wait_drain("t4_drain");
    check("t4_ready_empty", 32'(bus.res_ready), 32'd1);

    // One deferral, then issue with a simultaneous push
    send(10'h012, 10'h033, 1'b1, 1'b0, 2'd1);
    bus.res_valid = 1'b0;
    rd_valid   = 1'b1;
    rd_address = 10'h012;
    tick();
    check("t5_defer", 32'(bus.pht_update), 32'd0);
    rd_address = 10'h055;
    send(10'h013, 10'h034, 1'b0, 1'b0, 2'd2);
    bus.res_valid = 1'b0;
    rd_valid      = 1'b0;
    check("t5_issue",      32'(bus.pht_update), 32'd1);
    check("t5_issue_addr", 32'(bus.pht_address), 32'h012);
    tick();
    check("t5_next",       32'(bus.pht_update), 32'd1);
    check("t5_next_addr",  32'(bus.pht_address), 32'h013);
    tick();
    check("t5_count_kept", 32'(bus.pht_update), 32'd0);
    wait_drain("t5_drain");

    // Reset with a non-empty FIFO during recovery
    rd_valid   = 1'b1;
    rd_address = 10'h030;
    send(10'h030, 10'h011, 1'b1, 1'b1, 2'd0);
    send(10'h030, 10'h022, 1'b0, 1'b1, 2'd3);
    send(10'h030, 10'h044, 1'b1, 1'b1, 2'd2);
    bus.res_valid = 1'b0;
    check("t6_in_recover", 32'(ghr_valid), 32'd0);
    check("t6_ghr",        32'(ghr), 32'h089);
    check("t6_queued",     32'(bus.pht_update), 32'd0);
    rst = 1'b1;
    sb.delete();
    tick();
    check("t6_ready",     32'(bus.res_ready), 32'd1);
    check("t6_ghr_rst",   32'(ghr), 32'h000);
    check("t6_valid_rst", 32'(ghr_valid), 32'd1);
    check("t6_no_update", 32'(bus.pht_update), 32'd0);
    rst      = 1'b0;
    rd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_empty_after", 32'(bus.pht_update), 32'd0);
    end
    check("t6_ready_after", 32'(bus.res_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/yags_update_scheduler.md
Name: yags_update_scheduler

Overview:
- Sequences the YAGS direction PHT.
- Holds the speculative global history register (GHR) used for fetch-time lookups.
- Queues branch resolutions from execute in an in-order FIFO and drains them into the PHT update port one per cycle.
- Defers an update that collides with a same-cycle lookup, with a starvation bound, and restores the GHR on mispredict.

Parameters:
- GHR_SIZE, 10, global history width.
- PC_SIZE, 10, PC index width.
- FIFO_DEPTH, 4, pending-update entries (power of 2).
- MAX_DEFER, 3, consecutive deferral cycles before a forced update.
- RECOVER_CYCLES, 2, cycles GHR is invalid after mispredict.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pred_valid  in  1  fetch made a conditional-branch prediction this cycle.
- pred_taken  in  1  predicted direction.
- rd_valid  in  1  PHT lookup occurring this cycle.
- rd_address  in  PC_SIZE  lookup PC index.
- res_valid  in  1  branch resolved in execute.
- res_ready  out  1  FIFO can accept.
- res_pc  in  PC_SIZE  resolved branch PC index.
- res_history  in  GHR_SIZE  GHR snapshot taken at prediction.
- res_taken  in  1  actual direction.
- res_mispredict  in  1  prediction was wrong.
- res_counter  in  2  counter value read at prediction.
- ghr  out  GHR_SIZE  speculative history for lookup.
- ghr_valid  out  1  ghr usable; low during recovery.
- pht_update  out  1  write strobe to PHT.
- pht_miss_predict  out  1  to PHT miss_predict.
- pht_address  out  PC_SIZE  to PHT address.
- pht_history  out  GHR_SIZE  to PHT history.
- pht_actual_prediction  out  2  new counter value.

Behaviour:
- Reset (rst=1 at a clk edge):
  - ghr=0, ghr_valid=1, FIFO empty, res_ready=1.
  - All pht_* outputs 0; defer counter 0; FSM=RUN.
  - Reset mid-recovery or with a non-empty FIFO discards all state; queued updates are lost.
- FSM states: RUN, RECOVER.
  - RUN -> RECOVER on an accepted resolution with res_mispredict=1.
  - RECOVER counts RECOVER_CYCLES cycles, then -> RUN.
  - A further accepted mispredict in RECOVER restarts the count.
- GHR, registered, priority order:
  1. Accepted mispredict: ghr <= {res_history[GHR_SIZE-2:0], res_taken}. Overrides pred_valid in the same cycle.
  2. Else in RUN with pred_valid: ghr <= {ghr[GHR_SIZE-2:0], pred_taken}.
  3. pred_valid is ignored in RECOVER.
- ghr_valid=0 exactly while FSM=RECOVER.
- Accept:
  - Resolution accepted when res_valid && res_ready.
  - res_ready = (count < FIFO_DEPTH), based on registered count only; no same-cycle pop credit.
  - res_valid while !res_ready is ignored; the sender must hold.
- Entry contents: pc, history, mispredict, new counter.
  - New counter is a 2-bit saturating update of res_counter: taken -> min(res_counter+1, 3); not-taken -> max(res_counter-1, 0).
- Drain: each cycle with the FIFO non-empty, the head is either issued or deferred.
  - Defer when rd_valid && rd_address == head.pc && defer_cnt < MAX_DEFER. defer_cnt++.
  - Otherwise issue: pht_* outputs are registered from the head (1-cycle latency, pht_update high for one cycle), the head pops, and defer_cnt <= 0.
  - With the FIFO empty, pht_update=0 and the other pht_* outputs hold their last value.
  - Maximum throughput: one update per cycle.
- Push and pop in the same cycle are legal; count is unchanged.
- Pointer wrap is modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- Draining continues during RECOVER; queued entries are older than the mispredict and remain valid.

Test Plan:
1. Reset, then pred_valid with pred_taken=1,1,0 -> ghr=0x000 -> 0x001 -> 0x003 -> 0x006; ghr_valid=1.
2. Resolution pc=0x011, history=0x001, taken=1, counter=2, no mispredict, rd_valid=0 -> next cycle pht_update=1, pht_address=0x011, pht_history=0x001, pht_actual_prediction=3, pht_miss_predict=0. Repeat with counter=3 -> still 3; taken=0 with counter=0 -> 0.
3. Mispredict with history=0x0FE, taken=0, and pred_valid=1 in the same cycle -> ghr=0x1FC; ghr_valid=0 for 2 cycles; pred_valid ignored during that window; then 1.
4. Five back-to-back resolutions while rd_valid=1 with rd_address matching each head -> res_ready=0 after 4 accepted; first issue forced after 3 deferral cycles; then FIFO drains.
5. Head pc=0x012 with rd_address=0x012 for 1 cycle then different -> one deferral, issue on the 2nd cycle; a simultaneous push/pop leaves count unchanged.
6. rst asserted with 3 entries queued during RECOVER -> next cycle FIFO empty, res_ready=1, ghr=0, ghr_valid=1, no pht_update.
